stopwatch_core: RTL
===================

// Module: stopwatch_core
// PURPOSE
//  Time-keeping stage fed by the 1 Hz divided clock from the clock divider. Counts elapsed
//  time as BCD MM:SS and runs the start/stop/lap/clear control FSM from three raw buttons.
//  Drives the divider's stop input and presents four BCD digits to the display multiplexer.
//  All logic is on clk_in; the 1 Hz input is used only as an edge-detected enable.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable clk_in cycles before a button level is accepted (20 ms @ 50 MHz)
//  MAX_MIN          59         last minute value before wrap; total range 00:00..MAX_MIN:59
// PORTS
//  clk_in          in   1  system clock, 50 MHz
//  reset_n         in   1  asynchronous, active-low reset
//  tick_clk        in   1  1 Hz divided clock from the clock divider (level; edge-detected here)
//  btn_start_stop  in   1  raw pushbutton, active high
//  btn_lap         in   1  raw pushbutton, active high
//  btn_clear       in   1  raw pushbutton, active high
//  stop            out  1  to clock divider; 1 = hold divider counter
//  running         out  1  1 in RUN or LAP
//  lap_active      out  1  1 in LAP (display frozen)
//  sec_ones        out  4  BCD 0-9
//  sec_tens        out  4  BCD 0-5
//  min_ones        out  4  BCD 0-9
//  min_tens        out  4  BCD 0-(MAX_MIN/10)
//  rollover        out  1  one-cycle pulse when count wraps MAX_MIN:59 -> 00:00
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; live and frozen counts 00:00; stop=1; running=0;
//   lap_active=0; rollover=0; sync/debounce state cleared (all button levels treated as 0).
//  Tick: tick_clk -> 2-FF sync -> rising-edge detect = 1-cycle tick pulse. Live count updates
//   on the 3rd clk_in rising edge after tick_clk rises. Counts only when current state is RUN
//   or LAP; state changing in the same cycle as the tick does not affect that tick.
//  BCD increment: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones;
//   min_ones 9->0 carries to min_tens; at MAX_MIN:59 next tick -> 00:00, rollover=1 one cycle.
//  Buttons: 2-FF sync, then level accepted only after DEBOUNCE_CYCLES equal consecutive
//   samples; press event = 1-cycle pulse on debounced 0->1. Holding produces one event.
//  Event priority in one cycle: clear > start_stop > lap; lower-priority events dropped.
//  FSM:
//   IDLE : start_stop -> RUN. lap, clear ignored.
//   RUN  : start_stop -> PAUSE. lap -> LAP (frozen <= live in same edge). clear ignored.
//   LAP  : start_stop -> PAUSE (display returns to live). lap -> RUN. clear ignored.
//          live count keeps incrementing; outputs show frozen count.
//   PAUSE: start_stop -> RUN. clear -> IDLE, live and frozen <= 00:00. lap ignored.
//  Outputs: stop=1 in IDLE/PAUSE, 0 in RUN/LAP; digits = frozen in LAP else live; all outputs
//   registered, change one cycle after the causing event pulse.
//  Reset mid-operation: immediate return to reset values; no pending event survives.
// STRUCTURE
//  stopwatch_pkg: typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t;
//   typedef logic [3:0] bcd_t; typedef struct packed {bcd_t mt, mo, st, so;} sw_time_t.
//  Sub-module button_conditioner (sync + debounce + rising-edge pulse, param DEBOUNCE_CYCLES),
//   instantiated three times. FSM, tick detect and BCD counter inline.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, tick_clk driven directly)
//  1 reset, press start_stop, 5 tick_clk edges -> 00:05, stop=0, running=1.
//  2 from start, 3599 ticks -> 59:59; 1 more tick -> 00:00 with rollover high exactly 1 cycle.
//  3 run to 00:10, press lap, 3 ticks -> shows 00:10, lap_active=1; press lap -> shows 00:13.
//  4 at 00:07 press start_stop -> PAUSE, stop=1; 4 ticks -> still 00:07; clear -> 00:00, IDLE;
//    clear pressed in RUN -> ignored, count continues.
//  5 start_stop glitch 3 cycles wide -> no event; held 100 cycles -> exactly one event.
//  6 in PAUSE, start_stop and clear same cycle -> IDLE 00:00; reset_n low mid-RUN -> 00:00, stop=1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD time helpers for the stopwatch time-keeping stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t mt;
        bcd_t mo;
        bcd_t st;
        bcd_t so;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;

    // True when the count sits at the last representable value max_min:59.
    function automatic logic time_is_max(sw_time_t t, int unsigned max_min);
        return (t.mt == 4'(max_min / 10)) && (t.mo == 4'(max_min % 10)) &&
               (t.st == 4'd5) && (t.so == 4'd9);
    endfunction

    // One-second BCD increment with carries; wrap at the top is handled by the caller.
    function automatic sw_time_t time_inc(sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.so != 4'd9) begin
            r.so = t.so + 4'd1;
        end else begin
            r.so = 4'd0;
            if (t.st != 4'd5) begin
                r.st = t.st + 4'd1;
            end else begin
                r.st = 4'd0;
                if (t.mo != 4'd9) begin
                    r.mo = t.mo + 4'd1;
                end else begin
                    r.mo = 4'd0;
                    r.mt = t.mt + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton -> 2-FF sync -> debounce -> one-cycle press pulse on accepted 0->1.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level; accept on the Nth.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch: 1 Hz tick detect, start/stop/lap/clear FSM, display select.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_MIN         = 59
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       tick_clk,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       stop,
    output logic       running,
    output logic       lap_active,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       rollover
);

    logic      tick_s1_q, tick_s2_q, tick_s3_q;
    logic      tick_c;
    logic      p_ss, p_lap, p_clr;
    logic      ev_ss, ev_lap, ev_clr;

    sw_state_t state_q, state_d;
    sw_time_t  live_q, live_d;
    sw_time_t  frozen_q, frozen_d;
    sw_time_t  disp_q, disp_d;
    logic      stop_q, stop_d;
    logic      running_q, running_d;
    logic      lap_q, lap_d;
    logic      roll_q, roll_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .btn_i  (btn_start_stop),
        .press_o(p_ss)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .btn_i  (btn_lap),
        .press_o(p_lap)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .btn_i  (btn_clear),
        .press_o(p_clr)
    );

    // Synchronize the 1 Hz level and keep one extra stage for rising-edge detection.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tick_s1_q <= 1'b0;
            tick_s2_q <= 1'b0;
            tick_s3_q <= 1'b0;
        end else begin
            tick_s1_q <= tick_clk;
            tick_s2_q <= tick_s1_q;
            tick_s3_q <= tick_s2_q;
        end
    end

    assign tick_c = tick_s2_q & ~tick_s3_q;

    // One event per cycle: clear beats start_stop beats lap.
    assign ev_clr = p_clr;
    assign ev_ss  = p_ss & ~p_clr;
    assign ev_lap = p_lap & ~p_ss & ~p_clr;

    // Next state, counter update and registered output values.
    always_comb begin
        state_d  = state_q;
        live_d   = live_q;
        frozen_d = frozen_q;
        roll_d   = 1'b0;

        if (tick_c && (state_q == RUN || state_q == LAP)) begin
            if (time_is_max(live_q, MAX_MIN)) begin
                live_d = TIME_ZERO;
                roll_d = 1'b1;
            end else begin
                live_d = time_inc(live_q);
            end
        end

        case (state_q)
            IDLE: begin
                if (ev_ss) state_d = RUN;
            end
            RUN: begin
                if (ev_ss) begin
                    state_d = PAUSE;
                end else if (ev_lap) begin
                    state_d  = LAP;
                    frozen_d = live_q;
                end
            end
            LAP: begin
                if (ev_ss) begin
                    state_d = PAUSE;
                end else if (ev_lap) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (ev_clr) begin
                    state_d  = IDLE;
                    live_d   = TIME_ZERO;
                    frozen_d = TIME_ZERO;
                end else if (ev_ss) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        disp_d    = (state_d == LAP) ? frozen_d : live_d;
        stop_d    = (state_d == IDLE) || (state_d == PAUSE);
        running_d = (state_d == RUN) || (state_d == LAP);
        lap_d     = (state_d == LAP);
    end

    // State, counts and output registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            live_q    <= TIME_ZERO;
            frozen_q  <= TIME_ZERO;
            disp_q    <= TIME_ZERO;
            stop_q    <= 1'b1;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            roll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            frozen_q  <= frozen_d;
            disp_q    <= disp_d;
            stop_q    <= stop_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            roll_q    <= roll_d;
        end
    end

    assign stop       = stop_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign sec_ones   = disp_q.so;
    assign sec_tens   = disp_q.st;
    assign min_ones   = disp_q.mo;
    assign min_tens   = disp_q.mt;
    assign rollover   = roll_q;

endmodule
